// File: rtl/norm_share_sched_pkg.sv
// Shared constants and flag encoding for the shared leading-one/normalize scheduler.
// Default geometry: 4 fraction bits, 2 guard bits, 5-bit exponent, 4 lanes.
package norm_share_sched_pkg;

    localparam int SIG_WIDTH  = 4;
    localparam int LOW_EXPAND = 2;
    localparam int EXP_WIDTH  = 5;
    localparam int NUM_REQ    = 4;

    localparam int W       = SIG_WIDTH + 3 + LOW_EXPAND;
    localparam int POS_W   = $clog2(W);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int EXP_SAT = (1 << EXP_WIDTH) - 1;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } norm_flags_t;

    localparam norm_flags_t FLAGS_NONE = '{zero: 1'b0, ovf: 1'b0, unf: 1'b0};
    localparam norm_flags_t FLAGS_ZERO = '{zero: 1'b1, ovf: 1'b0, unf: 1'b0};
    localparam norm_flags_t FLAGS_UNF  = '{zero: 1'b1, ovf: 1'b0, unf: 1'b1};
    localparam norm_flags_t FLAGS_OVF  = '{zero: 1'b0, ovf: 1'b1, unf: 1'b0};

endpackage

// File: rtl/norm_share_sched_if.sv
// Lane request bus plus normalized result bus of the shared normalizer.
// The scheduler connects through the slave modport, the lanes/writeback side through master.
interface norm_share_sched_if
    import norm_share_sched_pkg::*;
#(
    parameter int N_REQ  = NUM_REQ,
    parameter int SIG_W  = W,
    parameter int EXP_W  = EXP_WIDTH,
    parameter int FRAC_W = SIG_WIDTH,
    parameter int LANE_W = ID_W
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*SIG_W-1:0] req_sig;
    logic [N_REQ*EXP_W-1:0] req_exp;
    logic                   out_valid;
    logic                   out_ready;
    logic [FRAC_W-1:0]      out_frac;
    logic [EXP_W-1:0]       out_exp;
    logic [LANE_W-1:0]      out_id;
    logic                   out_zero;
    logic                   out_ovf;
    logic                   out_unf;

    modport master (
        output req_valid, req_sig, req_exp, out_ready,
        input  req_ready, out_valid, out_frac, out_exp, out_id, out_zero, out_ovf, out_unf
    );

    modport slave (
        input  req_valid, req_sig, req_exp, out_ready,
        output req_ready, out_valid, out_frac, out_exp, out_id, out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/norm_share_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or after ptr, cyclically.
// ptr moves past the granted lane only when the grant is actually taken (advance).
module norm_share_sched_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_next;

    // Walk offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        int idx;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr_reg) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant[gi] = grant_valid && (grant_idx == ID_W'(gi));
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (advance && grant_valid) begin
            ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/norm_share_sched.sv
// Shares one leading-one/normalize datapath between accumulator lanes.
// Stage 1 captures the granted lane; stage 2 holds the normalized, lane-tagged result.
module norm_share_sched
    import norm_share_sched_pkg::*;
#(
    parameter int sigWidth   = SIG_WIDTH,
    parameter int low_expand = LOW_EXPAND,
    parameter int expWidth   = EXP_WIDTH,
    parameter int NUM_REQ    = norm_share_sched_pkg::NUM_REQ
) (
    input  logic               clk,
    input  logic               rst_n,
    norm_share_sched_if.slave  bus
);
    localparam int IN_W = sigWidth + 3 + low_expand;
    localparam int P_W  = $clog2(IN_W);
    localparam int I_W  = $clog2(NUM_REQ);
    localparam int E2_W = expWidth + 2;
    localparam logic signed [E2_W-1:0] E_SAT = E2_W'((1 << expWidth) - 1);

    logic               s2_load;
    logic               accept;
    logic               handshake;
    logic [NUM_REQ-1:0] grant;
    logic [I_W-1:0]     grant_idx;
    logic               grant_valid;

    logic                s1_valid_reg;
    logic [IN_W-1:0]     s1_sig_reg;
    logic [expWidth-1:0] s1_exp_reg;
    logic [I_W-1:0]      s1_id_reg;

    logic                out_valid_reg;
    logic [sigWidth-1:0] out_frac_reg;
    logic [expWidth-1:0] out_exp_reg;
    logic [I_W-1:0]      out_id_reg;
    norm_flags_t         out_flags_reg;

    logic [P_W-1:0]         pos;
    logic [IN_W-1:0]        shifted;
    logic signed [E2_W-1:0] e;
    logic [sigWidth-1:0]    frac_next;
    logic [expWidth-1:0]    exp_next;
    norm_flags_t            flags_next;
    logic                   unused_shift;

    assign s2_load   = !out_valid_reg || bus.out_ready;
    assign accept    = !s1_valid_reg || s2_load;
    assign handshake = accept && grant_valid;
    assign bus.req_ready = {NUM_REQ{accept}} & grant;

    norm_share_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (I_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (bus.req_valid),
        .advance     (accept),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // S1 empties on a drain with no new grant, so valid follows the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sig_reg   <= '0;
            s1_exp_reg   <= '0;
            s1_id_reg    <= '0;
        end else if (accept) begin
            s1_valid_reg <= handshake;
            if (handshake) begin
                s1_sig_reg <= bus.req_sig[grant_idx*IN_W +: IN_W];
                s1_exp_reg <= bus.req_exp[grant_idx*expWidth +: expWidth];
                s1_id_reg  <= grant_idx;
            end
        end
    end

    always_comb begin
        pos = '0;
        for (int b = 0; b < IN_W; b++) begin
            if (s1_sig_reg[b]) begin
                pos = P_W'(b);
            end
        end
    end

    assign shifted = s1_sig_reg << (P_W'(IN_W - 1) - pos);
    assign e       = E2_W'(s1_exp_reg) + E2_W'(pos) - E2_W'(sigWidth + low_expand);
    // The leading one and guard bits are deliberately dropped (truncation).
    assign unused_shift = ^{shifted[IN_W-1], shifted[IN_W-2-sigWidth:0]};

    always_comb begin
        frac_next  = '0;
        exp_next   = '0;
        flags_next = FLAGS_NONE;
        if (s1_sig_reg == '0) begin
            flags_next = FLAGS_ZERO;
        end else if (e <= 0) begin
            flags_next = FLAGS_UNF;
        end else if (e >= E_SAT) begin
            flags_next = FLAGS_OVF;
            exp_next   = '1;
        end else begin
            exp_next  = e[expWidth-1:0];
            frac_next = shifted[IN_W-2 -: sigWidth];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_frac_reg  <= '0;
            out_exp_reg   <= '0;
            out_id_reg    <= '0;
            out_flags_reg <= FLAGS_NONE;
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            out_frac_reg  <= frac_next;
            out_exp_reg   <= exp_next;
            out_id_reg    <= s1_id_reg;
            out_flags_reg <= flags_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_frac  = out_frac_reg;
    assign bus.out_exp   = out_exp_reg;
    assign bus.out_id    = out_id_reg;
    assign bus.out_zero  = out_flags_reg.zero;
    assign bus.out_ovf   = out_flags_reg.ovf;
    assign bus.out_unf   = out_flags_reg.unf;
endmodule

// File: tb/tb_norm_share_sched.sv
// Bench for norm_share_sched: per-lane feed queues, a reference normalizer and
// round-robin model fill a scoreboard that is checked as results leave the block.
module tb_norm_share_sched;
    import norm_share_sched_pkg::*;

    typedef struct packed {
        logic [SIG_WIDTH-1:0] frac;
        logic [EXP_WIDTH-1:0] exp;
        logic [ID_W-1:0]      id;
        logic                 zero;
        logic                 ovf;
        logic                 unf;
    } res_t;

    typedef struct packed {
        logic [W-1:0]         sig;
        logic [EXP_WIDTH-1:0] exp;
    } item_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    norm_share_sched_if bus ();

    norm_share_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    item_t            lane_q[NUM_REQ][$];
    res_t             sb[$];
    logic [NUM_REQ-1:0] hs_lane = '0;
    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;
    int hs_count    = 0;

    function automatic res_t model_norm(item_t it, int id);
        res_t r;
        logic [W-1:0] s;
        int sh, pos, e;
        r    = '0;
        r.id = ID_W'(id);
        if (it.sig == '0) begin
            r.zero = 1'b1;
            return r;
        end
        s  = it.sig;
        sh = 0;
        while (!s[W-1]) begin
            s  = s << 1;
            sh = sh + 1;
        end
        pos = W - 1 - sh;
        e   = int'(it.exp) + pos - (SIG_WIDTH + LOW_EXPAND);
        if (e <= 0) begin
            r.zero = 1'b1;
            r.unf  = 1'b1;
        end else if (e >= EXP_SAT) begin
            r.ovf = 1'b1;
            r.exp = '1;
        end else begin
            r.exp  = e[EXP_WIDTH-1:0];
            r.frac = s[W-2 -: SIG_WIDTH];
        end
        return r;
    endfunction

    function automatic res_t dut_res();
        return {bus.out_frac, bus.out_exp, bus.out_id, bus.out_zero, bus.out_ovf, bus.out_unf};
    endfunction

    // Monitor: arbitration model, scoreboard push on handshake, pop on output.
    always @(negedge clk) begin
        if (rst_n) begin
            int expg;
            int g;
            res_t act;
            res_t expv;
            hs_lane = bus.req_valid & bus.req_ready;
            if (bus.req_ready != '0) begin
                expg = -1;
                for (int off = NUM_REQ - 1; off >= 0; off--) begin
                    if (bus.req_valid[(model_ptr + off) % NUM_REQ]) expg = (model_ptr + off) % NUM_REQ;
                end
                vectors++;
                if (expg < 0 || bus.req_ready !== NUM_REQ'(1 << expg)) begin
                    miscompares++;
                    $display("FAIL grant: req_ready=%b valid=%b expected lane %0d", bus.req_ready, bus.req_valid, expg);
                end
            end
            if (hs_lane != '0) begin
                g = $clog2(int'(hs_lane));
                if (lane_q[g].size() > 0) sb.push_back(model_norm(lane_q[g][0], g));
                model_ptr = (g + 1) % NUM_REQ;
                hs_count++;
            end
            if (bus.out_valid && bus.out_ready) begin
                act = dut_res();
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL result: got %h, scoreboard empty", act);
                end else begin
                    expv = sb.pop_front();
                    if (act !== expv) begin
                        miscompares++;
                        $display("FAIL result: got %h expected %h", act, expv);
                    end
                end
            end
        end else begin
            hs_lane = '0;
        end
    end

    // Lane drivers: hold the queue head stable until its handshake.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_lane[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
            bus.req_valid[i] = (lane_q[i].size() > 0);
            if (lane_q[i].size() > 0) begin
                bus.req_sig[i*W +: W]                 = lane_q[i][0].sig;
                bus.req_exp[i*EXP_WIDTH +: EXP_WIDTH] = lane_q[i][0].exp;
            end
        end
    end

    task automatic wait_out(output res_t r, output bit ok, input int bound);
        ok = 1'b0;
        r  = '0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                r  = dut_res();
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #1;
            done = (sb.size() == 0) && !bus.out_valid;
            for (int i = 0; i < NUM_REQ; i++) if (lane_q[i].size() > 0) done = 1'b0;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s drain: outstanding=%0d, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || dut_res() !== res_t'(0) || bus.req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset: valid=%b out=%h ready=%b, required 0", bus.out_valid, dut_res(), bus.req_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit hs = 1'b0;
        lane_q[0].push_back('{sig: 9'h058, exp: 5'd10});
        for (int c = 0; c < 10 && !hs; c++) begin
            @(negedge clk);
            hs = bus.req_valid[0] && bus.req_ready[0];
        end
        @(negedge clk);
        vectors++;
        if (!hs || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latency1: hs=%b out_valid=%b, required hs=1 valid=0", hs, bus.out_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || dut_res() !== {4'b0110, 5'd10, 2'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL single_result: valid=%b out=%h", bus.out_valid, dut_res());
        end
        wait_drain("single");
    endtask

    task automatic test_lane2();
        res_t r;
        bit ok;
        lane_q[2].push_back('{sig: 9'h1A0, exp: 5'd10});
        lane_q[2].push_back('{sig: 9'h000, exp: 5'd7});
        wait_out(r, ok, 20);
        vectors++;
        if (!ok || r !== {4'b1010, 5'd12, 2'd2, 3'b000}) begin
            miscompares++;
            $display("FAIL lane2_norm: got %h ok=%b", r, ok);
        end
        wait_out(r, ok, 20);
        vectors++;
        if (!ok || r !== {4'b0000, 5'd0, 2'd2, 3'b100}) begin
            miscompares++;
            $display("FAIL lane2_zero: got %h ok=%b", r, ok);
        end
        wait_drain("lane2");
    endtask

    task automatic test_edges();
        res_t r;
        bit ok;
        lane_q[3].push_back('{sig: 9'h001, exp: 5'd3});
        lane_q[3].push_back('{sig: 9'h100, exp: 5'd30});
        wait_out(r, ok, 20);
        vectors++;
        if (!ok || r !== {4'b0000, 5'd0, 2'd3, 3'b101}) begin
            miscompares++;
            $display("FAIL underflow: got %h ok=%b", r, ok);
        end
        wait_out(r, ok, 20);
        vectors++;
        if (!ok || r !== {4'b0000, 5'd31, 2'd3, 3'b010}) begin
            miscompares++;
            $display("FAIL overflow: got %h ok=%b", r, ok);
        end
        wait_drain("edges");
    endtask

    task automatic test_back_to_back();
        res_t r;
        bit ok;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NUM_REQ; i++)
                lane_q[i].push_back('{sig: W'($urandom_range(0, (1 << W) - 1)),
                                      exp: EXP_WIDTH'($urandom_range(0, EXP_SAT))});
        wait_out(r, ok, 20);
        for (int k = 0; k < 3 * NUM_REQ; k++) begin
            vectors++;
            if (!ok || bus.out_valid !== 1'b1 || bus.out_id !== ID_W'(k % NUM_REQ)) begin
                miscompares++;
                $display("FAIL rr_stream[%0d]: valid=%b id=%0d, required valid=1 id=%0d",
                         k, bus.out_valid, bus.out_id, k % NUM_REQ);
            end
            @(negedge clk);
        end
        wait_drain("rr_stream");
    endtask

    task automatic test_backpressure();
        int start;
        res_t snap;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        start = hs_count;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NUM_REQ; i++)
                lane_q[i].push_back('{sig: W'($urandom_range(1, (1 << W) - 1)),
                                      exp: EXP_WIDTH'($urandom_range(4, 28))});
        repeat (4) @(negedge clk);
        #1;
        snap = dut_res();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (hs_count - start != 2) begin
            miscompares++;
            $display("FAIL stall_accepts: got %0d, required 2", hs_count - start);
        end
        vectors++;
        if (bus.req_ready !== '0 || bus.out_valid !== 1'b1 || dut_res() !== snap) begin
            miscompares++;
            $display("FAIL stall_hold: ready=%b valid=%b out=%h snap=%h", bus.req_ready, bus.out_valid, dut_res(), snap);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_reset_mid();
        res_t r;
        bit ok;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            lane_q[1].push_back('{sig: 9'h0F0, exp: 5'd9});
            lane_q[2].push_back('{sig: 9'h033, exp: 5'd12});
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_full: out_valid=%b, required 1", bus.out_valid);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: out_valid=%b, required 0", bus.out_valid);
        end
        for (int i = 0; i < NUM_REQ; i++) lane_q[i].delete();
        sb.delete();
        model_ptr = 0;
        @(negedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) lane_q[i].push_back('{sig: 9'h0C0, exp: EXP_WIDTH'(8 + i)});
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        wait_out(r, ok, 20);
        vectors++;
        if (!ok || r.id !== ID_W'(0)) begin
            miscompares++;
            $display("FAIL reset_first_grant: id=%0d ok=%b, required id 0", r.id, ok);
        end
        wait_drain("reset_mid");
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_sig   = '0;
        bus.req_exp   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_lane2();
        test_edges();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
